// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze renderer slice.
//   tile_t      - tile codes stored in the 2048 x 3-bit map RAM
//   wr_state_t  - states of the tile write-port FSM
//   MAP_*       - visible map geometry in tiles, TILE_BITS = log2(tile size)
//   C_*_DEF     - default 12-bit {R4,G4,B4} colours
package maze_pkg;

  localparam int MAP_COLS  = 40;
  localparam int MAP_ROWS  = 30;
  localparam int TILE_BITS = 4;
  localparam int ADDR_W    = 11;

  localparam logic [11:0] C_WALL_DEF   = 12'h00F;
  localparam logic [11:0] C_PELLET_DEF = 12'hFB8;
  localparam logic [11:0] C_DOOR_DEF   = 12'hF8F;

  // Codes 5..7 are never named; they render as empty.
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    WALL   = 3'd1,
    PELLET = 3'd2,
    POWER  = 3'd3,
    DOOR   = 3'd4
  } tile_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_READ  = 2'd1,
    WR_WRITE = 2'd2
  } wr_state_t;

  // Both normal and power pellets count towards clearing the level.
  function automatic logic is_pellet(input logic [2:0] code);
    return (code == PELLET) || (code == POWER);
  endfunction

  // Inclusive range test on an in-tile pixel offset.
  function automatic logic in_span(input logic [3:0] v, input logic [3:0] lo,
                                   input logic [3:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/maze_map_ram.sv
// maze_map_ram: true dual-port 2048 x 3-bit tile map, one BRAM.
//   clk     - clock for both ports
//   addr_a  - display read address {row,col}; q_a registered read data
//   addr_b  - game-side address; we_b/d_b write, q_b registered read data
// The contents are never reset; only port B writes change them.
module maze_map_ram
  import maze_pkg::*;
#(
  parameter string MAP_FILE = "maze.mem"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [2:0]        q_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic [2:0]        d_b,
  output logic [2:0]        q_b
);

  logic [2:0] mem [0:(1<<ADDR_W)-1];

  // Port A is read-only and feeds the render pipeline.
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
  end

  // Port B belongs to the write FSM: it reads the old code, then writes the new one.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= d_b;
    q_b <= mem[addr_b];
  end

endmodule

// File: rtl/maze_renderer.sv
// maze_renderer: pixel-colour stage behind the VGA timing generator.
//   clk, reset               - pixel clock, async active-high reset
//   x, y, video_on           - raster position and active-area flag
//   h_sync_in, v_sync_in     - raw syncs, re-timed to match the 3-cycle pipeline
//   wr_req/wr_col/wr_row/wr_tile, wr_ready - ready/valid tile write port
//   rgb, h_sync, v_sync      - colour and syncs, 3 cycles after their inputs
//   frame_tick               - one pulse per frame at the start of vertical blank
//   pellet_count, level_clear - pellets remaining, pulse when the last one goes
module maze_renderer
  import maze_pkg::*;
#(
  parameter string       MAP_FILE     = "maze.mem",
  parameter int          PELLET_INIT  = 240,
  parameter int          BLINK_FRAMES = 15,
  parameter logic [11:0] C_WALL       = C_WALL_DEF,
  parameter logic [11:0] C_PELLET     = C_PELLET_DEF,
  parameter logic [11:0] C_DOOR       = C_DOOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        wr_req,
  input  logic [5:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_tile,
  output logic        wr_ready,
  output logic [11:0] rgb,
  output logic        h_sync,
  output logic        v_sync,
  output logic        frame_tick,
  output logic [8:0]  pellet_count,
  output logic        level_clear
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [5:0] col_s1;
  logic [4:0] row_s1;
  logic [3:0] ox_s1, oy_s1, ox_s2, oy_s2;
  logic       vid_s1, hs_s1, vs_s1, vid_s2, hs_s2, vs_s2;
  logic [2:0] tile_s2;
  logic [11:0] pix_colour;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_hidden;

  wr_state_t  wr_state;
  logic [5:0] lat_col;
  logic [4:0] lat_row;
  logic [2:0] lat_tile;
  logic [2:0] old_tile;
  logic       lat_in_range;
  logic       ram_we;
  logic       clear_pending;

  maze_map_ram #(.MAP_FILE(MAP_FILE)) u_ram (
    .clk    (clk),
    .addr_a ({row_s1, col_s1}),
    .q_a    (tile_s2),
    .addr_b ({lat_row, lat_col}),
    .we_b   (ram_we),
    .d_b    (lat_tile),
    .q_b    (old_tile)
  );

  // Stages 1 and 2 of the render pipeline: split the raster position into
  // tile coordinates and in-tile offsets, then carry offsets, video_on and
  // syncs alongside the RAM read so everything reaches stage 3 together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1 <= '0;
      row_s1 <= '0;
      ox_s1  <= '0;
      oy_s1  <= '0;
      vid_s1 <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      ox_s2  <= '0;
      oy_s2  <= '0;
      vid_s2 <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
    end else begin
      col_s1 <= x[9:TILE_BITS];
      row_s1 <= y[8:TILE_BITS];
      ox_s1  <= x[TILE_BITS-1:0];
      oy_s1  <= y[TILE_BITS-1:0];
      vid_s1 <= video_on;
      hs_s1  <= h_sync_in;
      vs_s1  <= v_sync_in;
      ox_s2  <= ox_s1;
      oy_s2  <= oy_s1;
      vid_s2 <= vid_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
    end
  end

  // Colour of the current pixel from its tile code and position inside the
  // tile. Pellets are small centred squares, the door a two-line bar, and the
  // power pellet disappears during the hidden half of the blink.
  always_comb begin
    pix_colour = '0;
    case (tile_s2)
      WALL:   pix_colour = C_WALL;
      DOOR:   if (in_span(oy_s2, 4'd7, 4'd8)) pix_colour = C_DOOR;
      PELLET: if (in_span(ox_s2, 4'd6, 4'd9) && in_span(oy_s2, 4'd6, 4'd9))
                pix_colour = C_PELLET;
      POWER:  if (!blink_hidden && in_span(ox_s2, 4'd3, 4'd12) &&
                  in_span(oy_s2, 4'd3, 4'd12))
                pix_colour = C_PELLET;
      default: pix_colour = '0;
    endcase
    if (!vid_s2) pix_colour = '0;
  end

  // Stage 3: registered outputs, so colour and syncs leave together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb    <= '0;
      h_sync <= 1'b0;
      v_sync <= 1'b0;
    end else begin
      rgb    <= pix_colour;
      h_sync <= hs_s2;
      v_sync <= vs_s2;
    end
  end

  // Frame tick fires on the first blanking line; the blink counter advances
  // once per frame and flips the power-pellet phase every BLINK_FRAMES frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick   <= 1'b0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else begin
      frame_tick <= (x == 10'd0) && (y == 10'd480);
      if (frame_tick) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign lat_in_range = (lat_col < 6'(MAP_COLS)) && (lat_row < 5'(MAP_ROWS));
  assign ram_we       = (wr_state == WR_WRITE) && lat_in_range;

  // Write FSM: read-modify-write through port B so the pellet count can
  // compare old and new codes. Out-of-range requests still walk all three
  // states but neither touch the RAM nor the count. level_clear follows one
  // cycle after the count has reached zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state      <= WR_IDLE;
      wr_ready      <= 1'b1;
      lat_col       <= '0;
      lat_row       <= '0;
      lat_tile      <= '0;
      pellet_count  <= 9'(PELLET_INIT);
      clear_pending <= 1'b0;
      level_clear   <= 1'b0;
    end else begin
      clear_pending <= 1'b0;
      level_clear   <= clear_pending;
      case (wr_state)
        WR_IDLE: begin
          if (wr_req) begin
            lat_col  <= wr_col;
            lat_row  <= wr_row;
            lat_tile <= wr_tile;
            wr_state <= WR_READ;
            wr_ready <= 1'b0;
          end
        end
        WR_READ: begin
          wr_state <= WR_WRITE;
        end
        WR_WRITE: begin
          wr_state <= WR_IDLE;
          wr_ready <= 1'b1;
          if (lat_in_range) begin
            if (is_pellet(old_tile) && !is_pellet(lat_tile)) begin
              if (pellet_count != 9'd0) begin
                pellet_count <= pellet_count - 9'd1;
                if (pellet_count == 9'd1) clear_pending <= 1'b1;
              end
            end else if (!is_pellet(old_tile) && is_pellet(lat_tile)) begin
              if (pellet_count != 9'h1FF) pellet_count <= pellet_count + 9'd1;
            end
          end
        end
        default: begin
          wr_state <= WR_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
